// File: rtl/sdp_mrdma_ig_req_gen_if.sv
// ----------------------------------------------------------------------------
// sdp_mrdma_ig_req_gen_if
// Groups the two request-side handshakes of the MRDMA ingress request generator:
//   dma_rd_req_vld/rdy/pd : 32B-atom DMA read request, pd = {size[14:0], addr[63:0]}
//   ig2cq_pvld/prdy/pd    : 14-bit context push into the cq FIFO
// master : the request generator (drives valids and payloads)
// slave  : the DMA / cq FIFO side (drives the readies)
// ----------------------------------------------------------------------------
interface sdp_mrdma_ig_req_gen_if;
    logic        dma_rd_req_vld;
    logic        dma_rd_req_rdy;
    logic [78:0] dma_rd_req_pd;
    logic        ig2cq_pvld;
    logic        ig2cq_prdy;
    logic [13:0] ig2cq_pd;

    modport master (
        output dma_rd_req_vld, dma_rd_req_pd, ig2cq_pvld, ig2cq_pd,
        input  dma_rd_req_rdy, ig2cq_prdy
    );

    modport slave (
        input  dma_rd_req_vld, dma_rd_req_pd, ig2cq_pvld, ig2cq_pd,
        output dma_rd_req_rdy, ig2cq_prdy
    );
endinterface

// File: rtl/sdp_mrdma_ig_req_gen.sv
// ----------------------------------------------------------------------------
// sdp_mrdma_ig_req_gen
// Ingress request generator of the SDP MRDMA. After op_load it walks a
// height x width surface and issues DMA read requests of up to 8 atoms (32B
// each). Every request is paired with a context word pushed into the cq FIFO;
// both transfer in the same cycle or not at all. ig_done pulses one cycle
// after the last request of the layer is accepted.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   op_load                          : 1-cycle start pulse (ignored unless idle)
//   reg2dp_*                         : surface configuration, latched in CALC
//   req_if (master)                  : DMA request + cq context handshakes
//   ig_done                          : 1-cycle pulse after last accept
//   dp2reg_mrdma_stall_cnt           : stall perf counter
//
// Build option: define SDP_MRDMA_IG_PERF_EN to implement the stall counter
// (cycles in REQ without accept, saturating, cleared on an accepted op_load).
// Without it the counter output is tied to zero.
//
// state | meaning
// IDLE  | waiting for op_load
// CALC  | latch configuration, derive atoms per line
// REQ   | present current request until accepted
// ----------------------------------------------------------------------------
module sdp_mrdma_ig_req_gen (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        op_load,
    input  logic [31:0] reg2dp_src_base_addr_high,
    input  logic [26:0] reg2dp_src_base_addr_low,
    input  logic [26:0] reg2dp_src_line_stride,
    input  logic [12:0] reg2dp_width,
    input  logic [12:0] reg2dp_height,
    input  logic [1:0]  reg2dp_in_precision,
    sdp_mrdma_ig_req_gen_if.master req_if,
    output logic        ig_done,
    output logic [31:0] dp2reg_mrdma_stall_cnt
);

    localparam int          AW        = 64;
    localparam logic [13:0] MAX_ATOMS = 14'd8;

    typedef enum logic [1:0] {IDLE, CALC, REQ} state_t;

    state_t          state_q;
    logic [AW-1:0]   line_addr_q;
    logic [26:0]     stride_q;
    logic [13:0]     apl_q;
    logic [13:0]     atom_idx_q;
    logic [12:0]     line_idx_q;
    logic [12:0]     height_q;
    logic            done_q;

    logic [13:0]     width_p1;
    logic [14:0]     line_bytes;
    logic [14:0]     line_bytes_rnd;
    logic [13:0]     rem_atoms;
    logic [3:0]      req_atoms;
    logic [3:0]      req_atoms_m1;
    logic [AW-1:0]   req_addr;
    logic            line_end;
    logic            layer_end;
    logic            in_req;
    logic            accept;

    // Precision codes 1..3 all use 2 bytes per element.
    always_comb begin
        width_p1       = {1'b0, reg2dp_width} + 14'd1;
        line_bytes     = (reg2dp_in_precision != 2'd0) ? {width_p1, 1'b0} : {1'b0, width_p1};
        line_bytes_rnd = line_bytes + 15'd31;
    end

    // Remaining atoms are always >= 1 in REQ, so rem <= 8 means this request closes the line.
    always_comb begin
        rem_atoms    = apl_q - atom_idx_q;
        req_atoms    = (rem_atoms >= MAX_ATOMS) ? 4'd8 : rem_atoms[3:0];
        req_atoms_m1 = req_atoms - 4'd1;
        line_end     = (rem_atoms <= MAX_ATOMS);
        layer_end    = line_end && (line_idx_q == height_q);
        req_addr     = line_addr_q + {45'd0, atom_idx_q, 5'd0};
        in_req       = (state_q == REQ);
        accept       = in_req && req_if.dma_rd_req_rdy && req_if.ig2cq_prdy;
    end

    // Each valid is qualified by the other side's ready so both transfer together.
    always_comb begin
        req_if.dma_rd_req_vld = in_req && req_if.ig2cq_prdy;
        req_if.ig2cq_pvld     = in_req && req_if.dma_rd_req_rdy;
        req_if.dma_rd_req_pd  = in_req ? {11'd0, req_atoms_m1, req_addr} : 79'd0;
        req_if.ig2cq_pd       = in_req ? {9'd0, layer_end, line_end, req_atoms_m1[2:0]} : 14'd0;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            stride_q    <= '0;
            apl_q       <= '0;
            atom_idx_q  <= '0;
            line_idx_q  <= '0;
            height_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_load) state_q <= CALC;
                end
                CALC: begin
                    line_addr_q <= {reg2dp_src_base_addr_high, reg2dp_src_base_addr_low, 5'd0};
                    stride_q    <= reg2dp_src_line_stride;
                    apl_q       <= {4'd0, line_bytes_rnd[14:5]};
                    height_q    <= reg2dp_height;
                    atom_idx_q  <= '0;
                    line_idx_q  <= '0;
                    state_q     <= REQ;
                end
                REQ: begin
                    if (accept) begin
                        if (layer_end) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (line_end) begin
                            atom_idx_q  <= '0;
                            line_idx_q  <= line_idx_q + 13'd1;
                            line_addr_q <= line_addr_q + {32'd0, stride_q, 5'd0};
                        end else begin
                            atom_idx_q <= atom_idx_q + {10'd0, req_atoms};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ig_done = done_q;

`ifdef SDP_MRDMA_IG_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && op_load) begin
            stall_cnt_d = '0;
        end else if (in_req && !accept && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) stall_cnt_q <= '0;
        else                  stall_cnt_q <= stall_cnt_d;
    end

    assign dp2reg_mrdma_stall_cnt = stall_cnt_q;
`else
    assign dp2reg_mrdma_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_sdp_mrdma_ig_req_gen.sv
// ----------------------------------------------------------------------------
// tb_sdp_mrdma_ig_req_gen
// Directed bench for the MRDMA ingress request generator. Accepted requests
// and context words are logged at the falling edge and compared against
// hand-computed expected sequences.
// ----------------------------------------------------------------------------
module tb_sdp_mrdma_ig_req_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_load = 1'b0;
    logic [31:0] base_hi = '0;
    logic [26:0] base_lo = '0;
    logic [26:0] stride = '0;
    logic [12:0] width = '0;
    logic [12:0] height = '0;
    logic [1:0]  prec = '0;
    logic        ig_done;
    logic [31:0] stall_cnt;

    sdp_mrdma_ig_req_gen_if ifc();

    sdp_mrdma_ig_req_gen dut (
        .nvdla_core_clk           (clk),
        .nvdla_core_rstn          (rst_n),
        .op_load                  (op_load),
        .reg2dp_src_base_addr_high(base_hi),
        .reg2dp_src_base_addr_low (base_lo),
        .reg2dp_src_line_stride   (stride),
        .reg2dp_width             (width),
        .reg2dp_height            (height),
        .reg2dp_in_precision      (prec),
        .req_if                   (ifc),
        .ig_done                  (ig_done),
        .dp2reg_mrdma_stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int op_cyc = 0;
    int asym = 0;

    logic [78:0] req_q[$];
    logic [13:0] cq_q[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    logic [78:0] exp_pd[$];
    logic [13:0] exp_cq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.dma_rd_req_vld && ifc.dma_rd_req_rdy) begin
            req_q.push_back(ifc.dma_rd_req_pd);
            cq_q.push_back(ifc.ig2cq_pd);
            acc_cyc.push_back(cyc);
        end
        if ((ifc.dma_rd_req_vld && ifc.dma_rd_req_rdy) != (ifc.ig2cq_pvld && ifc.ig2cq_prdy))
            asym++;
        if (ig_done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        req_q.delete();
        cq_q.delete();
        acc_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic add_exp(input logic [14:0] sz, input logic [63:0] a, input logic [13:0] cq);
        exp_pd.push_back({sz, a});
        exp_cq.push_back(cq);
    endtask

    task automatic start_op(input logic [31:0] hi, input logic [26:0] lo, input logic [26:0] st,
                            input logic [12:0] w, input logic [12:0] h, input logic [1:0] p);
        @(posedge clk); #1;
        base_hi = hi; base_lo = lo; stride = st; width = w; height = h; prec = p;
        op_load = 1'b1;
        op_cyc  = cyc;
        @(posedge clk); #1;
        op_load = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic verify(input string tag);
        int n;
        chk($sformatf("%s_nreq", tag), 80'(req_q.size()), 80'(exp_pd.size()));
        n = (req_q.size() < exp_pd.size()) ? req_q.size() : exp_pd.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_pd%0d", tag, i), 80'(req_q[i]), 80'(exp_pd[i]));
            chk($sformatf("%s_cq%0d", tag, i), 80'(cq_q[i]), 80'(exp_cq[i]));
        end
        chk($sformatf("%s_ndone", tag), 80'(done_cyc.size()), 80'd1);
        if (done_cyc.size() > 0 && acc_cyc.size() > 0)
            chk($sformatf("%s_done_lat", tag), 80'(done_cyc[0] - acc_cyc[acc_cyc.size()-1]), 80'd1);
        exp_pd.delete();
        exp_cq.delete();
    endtask

    task automatic exp_t2();
        add_exp(15'd7, 64'h000, 14'h007);
        add_exp(15'd7, 64'h100, 14'h00F);
        add_exp(15'd7, 64'h400, 14'h007);
        add_exp(15'd7, 64'h500, 14'h01F);
    endtask

    initial begin
        ifc.dma_rd_req_rdy = 1'b1;
        ifc.ig2cq_prdy     = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_vld",   80'(ifc.dma_rd_req_vld), 80'd0);
        chk("rst_pvld",  80'(ifc.ig2cq_pvld), 80'd0);
        chk("rst_pd",    80'(ifc.dma_rd_req_pd), 80'd0);
        chk("rst_cqpd",  80'(ifc.ig2cq_pd), 80'd0);
        chk("rst_done",  80'(ig_done), 80'd0);
        chk("rst_stall", 80'(stall_cnt), 80'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: one 2-atom request at 0x1_0000_0000
        clear_log();
        start_op(32'h1, 27'd0, 27'd0, 13'd63, 13'd0, 2'd0);
        wait_done(50);
        add_exp(15'd1, 64'h1_0000_0000, 14'h019);
        if (acc_cyc.size() > 0) chk("t1_first_lat", 80'(acc_cyc[0] - op_cyc), 80'd2);
        verify("t1");
        chk("t1_stall", 80'(stall_cnt), 80'd0);

        // T2: two lines of 16 atoms, stride 0x400B
        clear_log();
        start_op(32'h0, 27'd0, 27'h20, 13'd255, 13'd1, 2'd1);
        wait_done(50);
        exp_t2();
        if (acc_cyc.size() == 4) chk("t2_b2b", 80'(acc_cyc[3] - acc_cyc[0]), 80'd3);
        verify("t2");

        // T3: 300B line -> 8 + 2 atoms
        clear_log();
        start_op(32'h0, 27'd0, 27'd0, 13'd299, 13'd0, 2'd0);
        wait_done(50);
        add_exp(15'd7, 64'h000, 14'h007);
        add_exp(15'd1, 64'h100, 14'h019);
        verify("t3");

        // T4: context FIFO full for 5 cycles in REQ
        clear_log();
        ifc.ig2cq_prdy = 1'b0;
        start_op(32'h0, 27'd0, 27'd0, 13'd299, 13'd0, 2'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_vld%0d", i),  80'(ifc.dma_rd_req_vld), 80'd0);
            chk($sformatf("t4_pvld%0d", i), 80'(ifc.ig2cq_pvld), 80'd1);
            chk($sformatf("t4_pd%0d", i),   80'(ifc.dma_rd_req_pd), 80'({15'd7, 64'h0}));
            @(posedge clk); #1;
        end
        ifc.ig2cq_prdy = 1'b1;
        @(negedge clk);
        chk("t4_vld_rise",  80'(ifc.dma_rd_req_vld), 80'd1);
        chk("t4_pvld_rise", 80'(ifc.ig2cq_pvld), 80'd1);
        wait_done(50);
        add_exp(15'd7, 64'h000, 14'h007);
        add_exp(15'd1, 64'h100, 14'h019);
        verify("t4");
`ifdef SDP_MRDMA_IG_PERF_EN
        chk("t4_stall", 80'(stall_cnt), 80'd5);
`else
        chk("t4_stall", 80'(stall_cnt), 80'd0);
`endif

        // T5: reset after two accepts of a T2 layer, then restart
        clear_log();
        start_op(32'h0, 27'd0, 27'h20, 13'd255, 13'd1, 2'd1);
        begin
            int n = 0;
            while (req_q.size() < 2 && n < 50) begin
                @(negedge clk); #2;
                n++;
            end
        end
        chk("t5_two_acc", 80'(req_q.size()), 80'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld",   80'(ifc.dma_rd_req_vld), 80'd0);
        chk("t5_rst_pvld",  80'(ifc.ig2cq_pvld), 80'd0);
        chk("t5_rst_pd",    80'(ifc.dma_rd_req_pd), 80'd0);
        chk("t5_rst_cqpd",  80'(ifc.ig2cq_pd), 80'd0);
        chk("t5_rst_stall", 80'(stall_cnt), 80'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("t5_rst_done",  80'(done_cyc.size()), 80'd0);
        rst_n = 1'b1;
        clear_log();
        start_op(32'h0, 27'd0, 27'h20, 13'd255, 13'd1, 2'd1);
        wait_done(50);
        exp_t2();
        verify("t5");

        // T6: op_load while in REQ is ignored
        clear_log();
        start_op(32'h0, 27'd0, 27'h20, 13'd255, 13'd1, 2'd1);
        @(posedge clk); #1;
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
        wait_done(50);
        exp_t2();
        verify("t6");

        // T7: max width int16 -> 64 requests per line, with random backpressure
        clear_log();
        start_op(32'h0, 27'd0, 27'd0, 13'd8191, 13'd0, 2'd2);
        begin
            int n = 0;
            while (done_cyc.size() == 0 && n < 800) begin
                @(posedge clk); #1;
                ifc.dma_rd_req_rdy = ($urandom_range(0, 3) != 0);
                ifc.ig2cq_prdy     = ($urandom_range(0, 3) != 0);
                n++;
            end
        end
        ifc.dma_rd_req_rdy = 1'b1;
        ifc.ig2cq_prdy     = 1'b1;
        wait_done(5);
        for (int i = 0; i < 64; i++)
            add_exp(15'd7, 64'(i * 256), (i == 63) ? 14'h01F : 14'h007);
        verify("t7");

        // T8: reserved precision (2B), width=16 -> 34B = 2 atoms; line address wraps mod 2^64
        clear_log();
        start_op(32'hFFFF_FFFF, 27'h7FF_FFFF, 27'd1, 13'd16, 13'd1, 2'd3);
        wait_done(50);
        add_exp(15'd1, 64'hFFFF_FFFF_FFFF_FFE0, 14'h009);
        add_exp(15'd1, 64'h0000_0000_0000_0000, 14'h019);
        verify("t8");

        // T9: width=0 int8 -> single atom
        clear_log();
        start_op(32'h0, 27'h10, 27'd0, 13'd0, 13'd0, 2'd0);
        wait_done(50);
        add_exp(15'd0, 64'h200, 14'h018);
        verify("t9");

        chk("handshake_joint", 80'(asym), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
